// File: rtl/pe_sched_pkg.sv
// Shared definitions for the PE issue scheduler.
//   sched_state_t   : controller states
//   NUM_FILTER_ROWS : filter-row packets issued at the start of every layer
//   calc_loc_w()    : width of the convolution-location field for a given
//                     filter element width
package pe_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILTER = 3'd1,
        IFMAP  = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sched_state_t;

    localparam int NUM_FILTER_ROWS = 5;

    function automatic int calc_loc_w(input int filter_width);
        return 5 * filter_width - 25;
    endfunction

endpackage

// File: rtl/pe_issue_scheduler_credit.sv
// credit_counter: number of ifmap packets issued but not yet acknowledged.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : an ifmap packet was accepted this cycle
//   dec        : a result acknowledgement arrived this cycle
//   count      : registered outstanding count, 0..MAX
//   full       : count == MAX
//   empty      : count == 0
//   underflow  : acknowledgement with nothing outstanding (count held at 0)
module credit_counter #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          underflow
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count_r;

    assign count     = count_r;
    assign full      = (count_r == MAX_C);
    assign empty     = (count_r == {CW{1'b0}});
    // A simultaneous accept and ack cancel, so only a lone ack can underflow.
    assign underflow = dec & ~inc & empty;

    // Outstanding-count register; saturates at both ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (inc && !dec && !full) begin
            count_r <= count_r + CW'(1);
        end else if (dec && !inc && !empty) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pe_issue_scheduler.sv
// pe_issue_scheduler: sequences one PE's work for a convolution layer.
// Issues five filter-row packets, then for every location an ifmap packet for
// timestep 0 followed by timestep 1. Ifmap issue is metered by a credit count
// of un-acknowledged packets.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin a layer (only honoured in IDLE)
//   issue_valid/ready   : packet handshake towards the packet bridge
//   issue_ifmapb_filter : 1 = ifmap packet, 0 = filter packet
//   issue_filter_row    : filter row (0 for ifmap packets)
//   issue_timestep      : ifmap timestep (0 for filter packets)
//   issue_conv_loc      : ifmap location (0 for filter packets)
//   ack_valid           : one pulse per result packet returned by the PE
//   busy                : controller is outside IDLE
//   done                : one-cycle pulse at layer completion
//   ack_err             : sticky, ack seen with nothing outstanding
module pe_issue_scheduler
    import pe_sched_pkg::*;
#(
    parameter int FILTER_WIDTH = 8,
    parameter int LOC_W        = calc_loc_w(FILTER_WIDTH),
    parameter int NUM_LOC      = 441,
    parameter int MAX_CREDIT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic             issue_ifmapb_filter,
    output logic [2:0]       issue_filter_row,
    output logic             issue_timestep,
    output logic [LOC_W-1:0] issue_conv_loc,
    input  logic             ack_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_err
);

    localparam int               CW       = $clog2(MAX_CREDIT + 1);
    localparam logic [2:0]       LAST_ROW = 3'(NUM_FILTER_ROWS - 1);
    localparam logic [LOC_W-1:0] LAST_LOC = LOC_W'(NUM_LOC - 1);
    localparam logic [CW-1:0]    MAX_M1   = CW'(MAX_CREDIT - 1);

    sched_state_t     state_r, state_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             ifmap_r, ifmap_nxt_s;
    logic [2:0]       row_r, row_nxt_s;
    logic             ts_r, ts_nxt_s;
    logic [LOC_W-1:0] loc_r, loc_nxt_s;
    logic             busy_r, done_r, ack_err_r;

    logic             xfer_s, inc_s, room_s, start_acc_s;
    logic [CW-1:0]    credit_count_s;
    logic             credit_full_s, credit_empty_s, credit_underflow_s;

    assign xfer_s = valid_r & issue_ready;
    assign inc_s  = xfer_s & ifmap_r;

    // Room for a newly presented ifmap packet, judged on the registered count
    // plus this cycle's accept; a same-cycle ack is deliberately not credited.
    assign room_s = inc_s ? (credit_count_s < MAX_M1) : ~credit_full_s;

    credit_counter #(
        .MAX (MAX_CREDIT),
        .CW  (CW)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_s),
        .dec       (ack_valid),
        .count     (credit_count_s),
        .full      (credit_full_s),
        .empty     (credit_empty_s),
        .underflow (credit_underflow_s)
    );

    // Next state and next presented packet. The field registers always hold
    // the packet being (or about to be) presented, so a stall holds them.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = valid_r;
        ifmap_nxt_s = ifmap_r;
        row_nxt_s   = row_r;
        ts_nxt_s    = ts_r;
        loc_nxt_s   = loc_r;
        start_acc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_nxt_s = FILTER;
                    valid_nxt_s = 1'b1;
                    ifmap_nxt_s = 1'b0;
                    row_nxt_s   = 3'd0;
                    ts_nxt_s    = 1'b0;
                    loc_nxt_s   = {LOC_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILTER: begin
                if (xfer_s && (row_r == LAST_ROW)) begin
                    state_nxt_s = IFMAP;
                    ifmap_nxt_s = 1'b1;
                    row_nxt_s   = 3'd0;
                    valid_nxt_s = room_s;
                end else if (xfer_s) begin
                    row_nxt_s   = row_r + 3'd1;
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            IFMAP: begin
                if (xfer_s && (loc_r == LAST_LOC) && ts_r) begin
                    state_nxt_s = DRAIN;
                    valid_nxt_s = 1'b0;
                end else if (xfer_s) begin
                    // Timestep 1 of a location always follows its timestep 0.
                    if (ts_r) begin
                        ts_nxt_s  = 1'b0;
                        loc_nxt_s = loc_r + LOC_W'(1);
                    end else begin
                        ts_nxt_s  = 1'b1;
                    end
                    valid_nxt_s = room_s;
                end else if (!valid_r) begin
                    valid_nxt_s = room_s;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            DRAIN: begin
                valid_nxt_s = 1'b0;
                if (credit_empty_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, presented packet and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            valid_r   <= 1'b0;
            ifmap_r   <= 1'b0;
            row_r     <= 3'd0;
            ts_r      <= 1'b0;
            loc_r     <= {LOC_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            valid_r   <= valid_nxt_s;
            ifmap_r   <= ifmap_nxt_s;
            row_r     <= row_nxt_s;
            ts_r      <= ts_nxt_s;
            loc_r     <= loc_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_nxt_s == DONE);
            ack_err_r <= (start_acc_s ? 1'b0 : ack_err_r) | credit_underflow_s;
        end
    end

    assign issue_valid         = valid_r;
    assign issue_ifmapb_filter = ifmap_r;
    assign issue_filter_row    = row_r;
    assign issue_timestep      = ts_r;
    assign issue_conv_loc      = loc_r;
    assign busy                = busy_r;
    assign done                = done_r;
    assign ack_err             = ack_err_r;

endmodule

// File: tb/tb_pe_issue_scheduler.sv
// Self-checking bench for pe_issue_scheduler (NUM_LOC=3, MAX_CREDIT=4).
// A packet-index reference model predicts every output each cycle; a vector
// table and directed sequences cover the specific corner cases.
module tb_pe_issue_scheduler;

    localparam int FW    = 8;
    localparam int LW    = 5 * FW - 25;
    localparam int NL    = 3;
    localparam int MC    = 4;
    localparam int NROWS = 5;
    localparam int NPK   = NROWS + 2 * NL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start = 1'b0;
    logic          issue_ready = 1'b0;
    logic          ack_valid = 1'b0;
    logic          issue_valid, issue_ifmapb_filter, issue_timestep;
    logic [2:0]    issue_filter_row;
    logic [LW-1:0] issue_conv_loc;
    logic          busy, done, ack_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pe_issue_scheduler #(
        .FILTER_WIDTH (FW),
        .NUM_LOC      (NL),
        .MAX_CREDIT   (MC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .issue_ifmapb_filter (issue_ifmapb_filter),
        .issue_filter_row    (issue_filter_row),
        .issue_timestep      (issue_timestep),
        .issue_conv_loc      (issue_conv_loc),
        .ack_valid           (ack_valid),
        .busy                (busy),
        .done                (done),
        .ack_err             (ack_err)
    );

    // Reference model: m_idx is the position in the layer's packet list
    // (0..4 filter rows, then 2*loc+timestep), m_out the un-acked ifmap count.
    int   m_idx = 0, m_out = 0;
    logic m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int   n_idx, n_out;
    logic n_busy, n_valid, n_done, n_err;
    logic xfer_m, inc_m, under_m, start_m;

    always_comb begin
        xfer_m  = m_valid && issue_ready;
        inc_m   = xfer_m && (m_idx >= NROWS);
        under_m = ack_valid && (m_out == 0) && !inc_m;
        start_m = !m_busy && start;
        n_err   = (start_m ? 1'b0 : m_err) | under_m;
        n_out   = under_m ? 0 : m_out + int'(inc_m) - int'(ack_valid);
        n_idx   = m_idx + int'(xfer_m);
        n_busy  = m_busy;
        n_valid = m_valid;
        n_done  = 1'b0;
        if (!m_busy) begin
            if (start) begin
                n_busy  = 1'b1;
                n_idx   = 0;
                n_valid = 1'b1;
            end
        end else if (m_done) begin
            n_busy  = 1'b0;
        end else if (m_idx == NPK) begin
            n_valid = 1'b0;
            n_done  = (m_out == 0);
        end else if (n_idx == NPK) begin
            n_valid = 1'b0;
        end else if (n_idx < NROWS) begin
            n_valid = 1'b1;
        end else if (m_valid && !xfer_m) begin
            n_valid = 1'b1;
        end else begin
            n_valid = (m_out + int'(inc_m)) < MC;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idx <= 0; m_out <= 0; m_busy <= 1'b0;
            m_valid <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
        end else begin
            m_idx <= n_idx; m_out <= n_out; m_busy <= n_busy;
            m_valid <= n_valid; m_done <= n_done; m_err <= n_err;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int ei, er, et, el;
        vectors++;
        cmp({tag, ".valid"},   int'(issue_valid), int'(m_valid));
        cmp({tag, ".busy"},    int'(busy),        int'(m_busy));
        cmp({tag, ".done"},    int'(done),        int'(m_done));
        cmp({tag, ".ack_err"}, int'(ack_err),     int'(m_err));
        if (m_valid) begin
            if (m_idx < NROWS) begin
                ei = 0; er = m_idx; et = 0; el = 0;
            end else begin
                ei = 1; er = 0; et = (m_idx - NROWS) % 2; el = (m_idx - NROWS) / 2;
            end
            cmp({tag, ".ifmapb_filter"}, int'(issue_ifmapb_filter), ei);
            cmp({tag, ".filter_row"},    int'(issue_filter_row),    er);
            cmp({tag, ".timestep"},      int'(issue_timestep),      et);
            cmp({tag, ".conv_loc"},      int'(issue_conv_loc),      el);
        end
    endtask

    task automatic cycle(input logic s, input logic r, input logic a, input string tag);
        start = s; issue_ready = r; ack_valid = a;
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    // One layer: start, ready pattern (0 always, 1 toggling, 2 random),
    // each ifmap transfer acked dly cycles later (dly<=0: random 1..6).
    task automatic run_layer(input int rmode, input int dly, input bit mid_start, input string tag);
        int q[$];
        int c = 0;
        int dones = 0;
        bit fin = 1'b0;
        logic s, r, a;
        while (!fin && c < 400) begin
            s = (c == 0) || (mid_start && m_idx >= NROWS + 1 && m_idx <= NROWS + 3);
            case (rmode)
                0:       r = 1'b1;
                1:       r = ((c % 2) == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            a = 1'b0;
            if (q.size() > 0 && q[0] <= c) begin
                a = 1'b1;
                void'(q.pop_front());
            end
            if (m_valid && r && m_idx >= NROWS)
                q.push_back(c + ((dly > 0) ? dly : int'($urandom_range(1, 6))));
            cycle(s, r, a, tag);
            if (done) dones++;
            if (m_done) fin = 1'b1;
            c++;
        end
        cycle(1'b0, 1'b0, 1'b0, tag);
        cmp({tag, ".busy_after_done"}, int'(busy), 0);
        cmp({tag, ".done_pulses"}, dones, 1);
    endtask

    typedef struct {
        logic s, r, a;
        logic ev, ei, et, eb, ed;
        int   er, el;
    } vec_t;

    function automatic vec_t mk(logic s, logic ev, logic ei, int er, logic et, int el);
        vec_t v;
        v.s = s; v.r = 1'b1; v.a = 1'b0;
        v.ev = ev; v.ei = ei; v.er = er; v.et = et; v.el = el;
        v.eb = 1'b1; v.ed = 1'b0;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1, 1'b0, 0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 2, 1'b0, 0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 3, 1'b0, 0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 0, 1'b0, 0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 0, 1'b1, 0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 0, 1'b0, 1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b1, 0, 1'b1, 1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_model("reset");
        cmp("reset.valid", int'(issue_valid), 0);
        cmp("reset.busy", int'(busy), 0);
        cmp("reset.loc", int'(issue_conv_loc), 0);
        reset = 1'b0;

        // Ready always high, no acks: filter rows then 4 ifmap packets, stall.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].s, tbl[i].r, tbl[i].a, "tbl");
            cmp($sformatf("tbl[%0d].valid", i), int'(issue_valid), int'(tbl[i].ev));
            cmp($sformatf("tbl[%0d].busy", i),  int'(busy),        int'(tbl[i].eb));
            cmp($sformatf("tbl[%0d].done", i),  int'(done),        int'(tbl[i].ed));
            if (tbl[i].ev) begin
                cmp($sformatf("tbl[%0d].ifmapb", i), int'(issue_ifmapb_filter), int'(tbl[i].ei));
                cmp($sformatf("tbl[%0d].row", i),    int'(issue_filter_row),    tbl[i].er);
                cmp($sformatf("tbl[%0d].ts", i),     int'(issue_timestep),      int'(tbl[i].et));
                cmp($sformatf("tbl[%0d].loc", i),    int'(issue_conv_loc),      tbl[i].el);
            end
        end

        // Ack at credit 4 reopens issue one cycle later; an ack coincident
        // with an accept at credit 3 keeps the count at 3 (so issue pauses).
        cycle(1'b0, 1'b1, 1'b1, "reopen");
        cmp("reopen.valid_same", int'(issue_valid), 0);
        cycle(1'b0, 1'b1, 1'b0, "reopen");
        cmp("reopen.valid_next", int'(issue_valid), 1);
        cmp("reopen.loc", int'(issue_conv_loc), 2);
        cycle(1'b0, 1'b1, 1'b1, "coinc");
        cmp("coinc.valid", int'(issue_valid), 0);
        cycle(1'b0, 1'b1, 1'b0, "coinc");
        cmp("coinc.valid_next", int'(issue_valid), 1);
        cmp("coinc.ts", int'(issue_timestep), 1);
        cycle(1'b0, 1'b1, 1'b0, "last");
        cmp("last.valid", int'(issue_valid), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, "drain");
        cmp("drain.done_early", int'(done), 0);
        cycle(1'b0, 1'b0, 1'b0, "drain");
        cmp("drain.done", int'(done), 1);
        cmp("drain.busy", int'(busy), 1);
        cycle(1'b0, 1'b0, 1'b0, "drain");
        cmp("drain.done_once", int'(done), 0);
        cmp("drain.busy_low", int'(busy), 0);

        // Ack in IDLE sets a sticky error, cleared by the next start.
        cycle(1'b0, 1'b0, 1'b1, "idle_ack");
        cmp("idle_ack.err", int'(ack_err), 1);
        cycle(1'b0, 1'b0, 1'b0, "idle_ack");
        cycle(1'b0, 1'b0, 1'b0, "idle_ack");
        cmp("idle_ack.sticky", int'(ack_err), 1);

        run_layer(0, 2, 1'b1, "ack2_midstart");
        cmp("ack2.err_cleared", int'(ack_err), 0);
        run_layer(1, 3, 1'b0, "toggle");
        for (int k = 0; k < 20; k++)
            run_layer(2, 0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));

        // Asynchronous reset while (1,t1) is presented, then a fresh start.
        cycle(1'b1, 1'b1, 1'b0, "rst_seq");
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, "rst_seq");
        cmp("rst_seq.loc", int'(issue_conv_loc), 1);
        cmp("rst_seq.ts", int'(issue_timestep), 1);
        reset = 1'b1;
        #1;
        check_model("async_reset");
        cmp("async_reset.valid", int'(issue_valid), 0);
        cmp("async_reset.busy", int'(busy), 0);
        cmp("async_reset.ifmapb", int'(issue_ifmapb_filter), 0);
        cmp("async_reset.ts", int'(issue_timestep), 0);
        cmp("async_reset.loc", int'(issue_conv_loc), 0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, "restart");
        cmp("restart.valid", int'(issue_valid), 1);
        cmp("restart.row", int'(issue_filter_row), 0);
        cmp("restart.ifmapb", int'(issue_ifmapb_filter), 0);
        cmp("restart.busy", int'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_issue_scheduler.md
# pe_issue_scheduler

Clocked controller that sequences one PE's work for a convolution layer. It issues five filter-row packets, then ifmap packets for every convolution location, interleaved as timestep 0 then timestep 1 per location. It meters issue against returned result acknowledgements with a credit counter. It sits in front of the packet bridge feeding the PE's `Packet_in`, and consumes the ack pulses derived from the PE's `Packet_out`.

## Interface
Parameters:
- `FILTER_WIDTH`, 8: filter element width; sets location field width.
- `LOC_W`, 5*FILTER_WIDTH-25: conv-location field width (15 at default).
- `NUM_LOC`, 441: convolution locations per layer (1..2^LOC_W).
- `MAX_CREDIT`, 4: max ifmap packets outstanding (un-acked), 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous active-high reset.
- `start` in 1: begin a layer; sampled only in IDLE.
- `issue_valid` out 1: issue fields valid.
- `issue_ready` in 1: downstream bridge accepts.
- `issue_ifmapb_filter` out 1: 1 = ifmap packet, 0 = filter packet.
- `issue_filter_row` out 3: filter row 0..4; 0 for ifmap packets.
- `issue_timestep` out 1: timestep of ifmap packet; 0 for filter packets.
- `issue_conv_loc` out LOC_W: location index; 0 for filter packets.
- `ack_valid` in 1: one-cycle pulse per result packet returned by the PE.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at layer completion.
- `ack_err` out 1: sticky; ack received with zero outstanding. Cleared by reset or accepted `start`.

## Operation
States: IDLE, FILTER, IFMAP, DRAIN, DONE.
- **IDLE**: `start` moves to FILTER, clears `ack_err`, row counter, location counter and timestep bit.
- **FILTER**: issues rows 0,1,2,3,4 with `ifmapb_filter=0`. Filter packets consume no credit. After row 4 is accepted, go to IFMAP.
- **IFMAP**: issue order is (loc0,t0),(loc0,t1),(loc1,t0)…(NUM_LOC-1,t1). The per-location interleave is mandatory: the PE residue loop holds one pending residue. Each accepted ifmap packet increments `credit`. After (NUM_LOC-1,t1) is accepted, go to DRAIN.
- **DRAIN**: no issue. When `credit==0`, go to DONE.
- **DONE**: `done=1` for exactly one cycle, then IDLE.

Credit rules:
- `credit` width is clog2(MAX_CREDIT+1).
- An ack decrements `credit`. A simultaneous accept and ack leaves it unchanged.
- An ack at `credit==0` sets `ack_err` and leaves `credit` at 0.

Other rules:
- `start` is ignored outside IDLE.
- Location counter wraps to 0 only on layer restart. It never exceeds NUM_LOC-1.

## Timing
- All outputs are registered.
- Reset values: `issue_valid=0`, all issue fields 0, `busy=0`, `done=0`, `ack_err=0`, `credit=0`, state IDLE.
- Latency: `start` high at edge N gives `busy=1` and the row-0 issue valid after edge N. The first issue is visible one cycle after `start`.
- Handshake:
  - Transfer occurs on an edge with `issue_valid && issue_ready`.
  - While `valid && !ready`, all fields hold stable and valid stays high.
  - The next packet is presented the cycle after transfer, giving back-to-back throughput of 1 packet/cycle.
- Credit gating:
  - In IFMAP, `issue_valid` is deasserted while `credit==MAX_CREDIT`.
  - Gating uses the registered count (no same-cycle ack bypass), so an ack reopens issue one cycle later.
  - `issue_valid` is never withdrawn once raised without a transfer. The gating check is applied only when presenting a new packet.
- Done: `done` is asserted the cycle after `credit` reaches 0 in DRAIN.
- Reset mid-operation: returns immediately to reset values. Outstanding acks arriving afterward in IDLE set `ack_err`; that is acceptable and documented.

## Structure
- Shared package `pe_sched_pkg`:
  - state enum `sched_state_t` {IDLE, FILTER, IFMAP, DRAIN, DONE}.
  - constant `NUM_FILTER_ROWS=5`.
  - function computing `LOC_W` from `FILTER_WIDTH`.
- One sub-module: `credit_counter` (parameter MAX; inputs inc, dec; outputs count, full, empty, underflow).

## Test plan
- Reset, then `start` with `issue_ready`=1 and no acks, NUM_LOC=3, MAX_CREDIT=4 -> rows 0..4, then (0,t0),(0,t1),(1,t0),(1,t1). Stall at credit 4, `busy=1`, no `done`.
- Same config, ack returned 2 cycles after each issue -> all 6 ifmap packets issued in order. `done` pulses once, 1 cycle after the 6th ack. `busy` falls with it.
- `issue_ready` toggling 0/1 every cycle -> fields stable across every stall, no packet duplicated or skipped, order identical to the first test.
- Ack coincident with an issue at credit 3 -> credit stays 3. Ack in IDLE -> `ack_err`=1 and sticky until the next `start`.
- `start` pulsed during IFMAP -> ignored, sequence unchanged.
- `reset` asserted mid-IFMAP at (1,t1) -> outputs return to reset values asynchronously. A new `start` restarts at filter row 0.
